// File: rtl/hit_lives_if.sv
// hit_lives_if
// Groups the frame/hit/restart inputs and the lives/visibility outputs of the
// hit and lives manager into one bundle.
//   master : driven by the game controller side (frame strobe, hit, restart),
//            observes lives and player state.
//   slave  : the hit_lives_manager itself.
// Signals:
//   startOfFrame    : one-cycle pulse at each frame start
//   hit_pulse       : one-cycle collision pulse, at most one per frame
//   restart         : one-cycle new-game request
//   lives           : remaining lives
//   invulnerable    : high during the post-hit window
//   player_visible  : draw enable for the player sprite
//   game_over       : level, high while the game is over
//   life_lost_pulse : one-cycle pulse per accepted hit
//   game_over_pulse : one-cycle pulse on entry to game over
interface hit_lives_if #(
  parameter int LIVES_W = 3
);
  logic               startOfFrame;
  logic               hit_pulse;
  logic               restart;
  logic [LIVES_W-1:0] lives;
  logic               invulnerable;
  logic               player_visible;
  logic               game_over;
  logic               life_lost_pulse;
  logic               game_over_pulse;

  modport master (
    output startOfFrame,
    output hit_pulse,
    output restart,
    input  lives,
    input  invulnerable,
    input  player_visible,
    input  game_over,
    input  life_lost_pulse,
    input  game_over_pulse
  );

  modport slave (
    input  startOfFrame,
    input  hit_pulse,
    input  restart,
    output lives,
    output invulnerable,
    output player_visible,
    output game_over,
    output life_lost_pulse,
    output game_over_pulse
  );
endinterface

// File: rtl/hit_lives_manager.sv
// hit_lives_manager
// Turns each accepted collision pulse into a life decrement, opens a
// frame-counted invulnerability window during which the player sprite blinks,
// and latches game over when the last life is lost. All outputs are registered.
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : hit_lives_if.slave (frame strobe, hit, restart in; lives,
//            invulnerable, player_visible, game_over and pulses out)
module hit_lives_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int LIVES_W       = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4,
  parameter int CNT_W         = 8
) (
  input  logic         clk,
  input  logic         resetN,
  hit_lives_if.slave   bus
);

  localparam logic [1:0] ST_PLAYING   = 2'd0;
  localparam logic [1:0] ST_INVULN    = 2'd1;
  localparam logic [1:0] ST_GAME_OVER = 2'd2;

  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_ZERO  = {LIVES_W{1'b0}};
  localparam logic [CNT_W-1:0]   WINDOW_LEN  = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};

  logic [1:0]         state_r,        state_s;
  logic [LIVES_W-1:0] lives_r,        lives_s;
  logic [CNT_W-1:0]   frame_cnt_r,    frame_cnt_s;
  logic [CNT_W-1:0]   blink_cnt_r,    blink_cnt_s;
  logic               visible_r,      visible_s;
  logic               invuln_r,       invuln_s;
  logic               game_over_r,    game_over_s;
  logic               life_lost_r,    life_lost_s;
  logic               go_pulse_r,     go_pulse_s;

  // Next-state and next-output computation; restart beats hit beats frame.
  always_comb begin
    state_s     = state_r;
    lives_s     = lives_r;
    frame_cnt_s = frame_cnt_r;
    blink_cnt_s = blink_cnt_r;
    visible_s   = visible_r;
    life_lost_s = 1'b0;
    go_pulse_s  = 1'b0;

    if (bus.restart) begin
      state_s     = ST_PLAYING;
      lives_s     = LIVES_INIT;
      frame_cnt_s = CNT_ZERO;
      blink_cnt_s = CNT_ZERO;
      visible_s   = 1'b1;
    end else begin
      case (state_r)
        ST_PLAYING: begin
          // The lives_r guard keeps the counter from wrapping even if the
          // register were ever corrupted to zero while still playing.
          if (bus.hit_pulse && (lives_r != LIVES_ZERO)) begin
            life_lost_s = 1'b1;
            lives_s     = lives_r - LIVES_ONE;
            if (lives_r == LIVES_ONE) begin
              state_s    = ST_GAME_OVER;
              go_pulse_s = 1'b1;
              visible_s  = 1'b1;
            end else begin
              state_s     = ST_INVULN;
              frame_cnt_s = WINDOW_LEN;
              blink_cnt_s = CNT_ZERO;
              visible_s   = 1'b0;
            end
          end else begin
            visible_s = 1'b1;
          end
        end

        ST_INVULN: begin
          // Hits are ignored here, including one coincident with the exit
          // frame; only frame strobes advance the window.
          if (bus.startOfFrame) begin
            if (frame_cnt_r == CNT_ONE) begin
              state_s     = ST_PLAYING;
              frame_cnt_s = CNT_ZERO;
              blink_cnt_s = CNT_ZERO;
              visible_s   = 1'b1;
            end else begin
              frame_cnt_s = frame_cnt_r - CNT_ONE;
              if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_s = CNT_ZERO;
                visible_s   = ~visible_r;
              end else begin
                blink_cnt_s = blink_cnt_r + CNT_ONE;
              end
            end
          end else begin
            frame_cnt_s = frame_cnt_r;
          end
        end

        ST_GAME_OVER: begin
          visible_s = 1'b1;
        end

        default: begin
          // Unreachable encoding: recover to a safe playing state.
          state_s     = ST_PLAYING;
          frame_cnt_s = CNT_ZERO;
          blink_cnt_s = CNT_ZERO;
          visible_s   = 1'b1;
        end
      endcase
    end

    invuln_s    = (state_s == ST_INVULN);
    game_over_s = (state_s == ST_GAME_OVER);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_PLAYING;
      lives_r     <= LIVES_INIT;
      frame_cnt_r <= CNT_ZERO;
      blink_cnt_r <= CNT_ZERO;
      visible_r   <= 1'b1;
      invuln_r    <= 1'b0;
      game_over_r <= 1'b0;
      life_lost_r <= 1'b0;
      go_pulse_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      lives_r     <= lives_s;
      frame_cnt_r <= frame_cnt_s;
      blink_cnt_r <= blink_cnt_s;
      visible_r   <= visible_s;
      invuln_r    <= invuln_s;
      game_over_r <= game_over_s;
      life_lost_r <= life_lost_s;
      go_pulse_r  <= go_pulse_s;
    end
  end

  assign bus.lives           = lives_r;
  assign bus.invulnerable    = invuln_r;
  assign bus.player_visible  = visible_r;
  assign bus.game_over       = game_over_r;
  assign bus.life_lost_pulse = life_lost_r;
  assign bus.game_over_pulse = go_pulse_r;

endmodule

// File: tb/tb_hit_lives_manager.sv
// tb_hit_lives_manager
// Self-checking bench: a reference model predicts the outputs for every
// driven cycle, pushes them to a scoreboard queue, and the queue is popped and
// compared one cycle later. Directed checks against fixed values cover the
// scenarios of interest (single hit, window hits, game over, restart, async
// reset mid-window); a random phase follows.
module tb_hit_lives_manager;

  localparam int INIT_LIVES = 3;
  localparam int INV_FR     = 4;
  localparam int BLK_FR     = 2;

  typedef struct packed {
    logic [2:0] lives;
    logic       inv;
    logic       vis;
    logic       go;
    logic       llp;
    logic       gop;
  } exp_t;

  logic clk;
  logic resetN;
  int   n_total;
  int   n_bad;
  int   cyc;
  exp_t sb_q[$];

  // model state: 0 playing, 1 invulnerable, 2 game over
  int   m_mode;
  int   m_lives;
  int   m_left;
  int   m_blink;
  logic m_vis;

  hit_lives_if #(.LIVES_W(3)) bus ();

  hit_lives_manager #(
    .INIT_LIVES(INIT_LIVES), .LIVES_W(3), .INVULN_FRAMES(INV_FR),
    .BLINK_FRAMES(BLK_FR), .CNT_W(8)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=%0d required=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_lives = INIT_LIVES;
    m_left  = 0;
    m_blink = 0;
    m_vis   = 1'b1;
  endtask

  // Advance the model by one clock with the given inputs and return what the
  // outputs should read afterwards.
  task automatic model_step(input logic sof, input logic hit, input logic rst, output exp_t e);
    e.llp = 1'b0;
    e.gop = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_mode == 0 && hit && m_lives > 0) begin
      e.llp   = 1'b1;
      m_lives = m_lives - 1;
      if (m_lives == 0) begin
        m_mode = 2;
        e.gop  = 1'b1;
        m_vis  = 1'b1;
      end else begin
        m_mode  = 1;
        m_left  = INV_FR;
        m_blink = 0;
        m_vis   = 1'b0;
      end
    end else if (m_mode == 1 && sof) begin
      if (m_left == 1) begin
        m_mode = 0; m_left = 0; m_blink = 0; m_vis = 1'b1;
      end else begin
        m_left = m_left - 1;
        if (m_blink == BLK_FR - 1) begin
          m_blink = 0;
          m_vis   = ~m_vis;
        end else begin
          m_blink = m_blink + 1;
        end
      end
    end
    e.lives = 3'(m_lives);
    e.inv   = (m_mode == 1);
    e.go    = (m_mode == 2);
    e.vis   = m_vis;
  endtask

  function automatic logic sof_next();
    return (cyc % 10 == 9);
  endfunction

  task automatic tick(input logic hit, input logic rst);
    logic sof;
    exp_t e;
    exp_t got;
    @(negedge clk);
    sof = sof_next();
    cyc++;
    bus.startOfFrame = sof;
    bus.hit_pulse    = hit;
    bus.restart      = rst;
    model_step(sof, hit, rst, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      check_val("sb_lives", int'(bus.lives), int'(got.lives));
      check_val("sb_inv",   int'(bus.invulnerable), int'(got.inv));
      check_val("sb_vis",   int'(bus.player_visible), int'(got.vis));
      check_val("sb_go",    int'(bus.game_over), int'(got.go));
      check_val("sb_llp",   int'(bus.life_lost_pulse), int'(got.llp));
      check_val("sb_gop",   int'(bus.game_over_pulse), int'(got.gop));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  // Idle until k frame strobes have been consumed (bounded by cycle count).
  task automatic wait_frames(input int k);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < k; i++) begin
      if (sof_next()) seen++;
      tick(1'b0, 1'b0);
    end
    check_val("wait_frames_bound", seen, k);
  endtask

  initial begin
    int   frames;
    logic hit_used;
    logic h;
    logic r;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    bus.startOfFrame = 1'b0;
    bus.hit_pulse    = 1'b0;
    bus.restart      = 1'b0;
    resetN = 1'b0;
    model_reset();
    #23;
    check_val("rst_lives", int'(bus.lives), 3);
    check_val("rst_vis",   int'(bus.player_visible), 1);
    check_val("rst_inv",   int'(bus.invulnerable), 0);
    check_val("rst_go",    int'(bus.game_over), 0);
    check_val("rst_llp",   int'(bus.life_lost_pulse), 0);
    check_val("rst_gop",   int'(bus.game_over_pulse), 0);
    @(negedge clk);
    resetN = 1'b1;

    // single hit away from a frame strobe
    tick(1'b1, 1'b0);
    check_val("hit1_lives", int'(bus.lives), 2);
    check_val("hit1_llp",   int'(bus.life_lost_pulse), 1);
    check_val("hit1_inv",   int'(bus.invulnerable), 1);
    check_val("hit1_vis",   int'(bus.player_visible), 0);
    tick(1'b0, 1'b0);
    check_val("hit1_llp_one_cycle", int'(bus.life_lost_pulse), 0);

    // hits on every frame strobe during the window, including the exit one
    frames = 0;
    for (int i = 0; i < 200 && frames < INV_FR; i++) begin
      h = sof_next();
      if (h) frames++;
      tick(h, 1'b0);
      if (frames == 2 && h) check_val("blink_after_f2", int'(bus.player_visible), 1);
    end
    check_val("win_lives", int'(bus.lives), 2);
    check_val("win_inv",   int'(bus.invulnerable), 0);
    check_val("win_vis",   int'(bus.player_visible), 1);
    tick(1'b1, 1'b0);
    check_val("hit2_lives", int'(bus.lives), 1);

    // last life: game over
    wait_frames(INV_FR);
    tick(1'b1, 1'b0);
    check_val("hit3_lives", int'(bus.lives), 0);
    check_val("hit3_gop",   int'(bus.game_over_pulse), 1);
    check_val("hit3_go",    int'(bus.game_over), 1);
    check_val("hit3_inv",   int'(bus.invulnerable), 0);
    tick(1'b0, 1'b0);
    check_val("gop_one_cycle", int'(bus.game_over_pulse), 0);
    for (int i = 0; i < 25; i++) tick(sof_next(), 1'b0);
    check_val("go_lives_hold", int'(bus.lives), 0);

    // restart from game over, then restart coincident with a hit
    tick(1'b0, 1'b1);
    check_val("rs_lives", int'(bus.lives), 3);
    check_val("rs_go",    int'(bus.game_over), 0);
    tick(1'b1, 1'b1);
    check_val("rs_hit_lives", int'(bus.lives), 3);
    check_val("rs_hit_llp",   int'(bus.life_lost_pulse), 0);

    // restart coincident with the window exit frame
    tick(1'b1, 1'b0);
    wait_frames(INV_FR - 1);
    for (int i = 0; i < 20 && !sof_next(); i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check_val("rs_exit_lives", int'(bus.lives), 3);
    check_val("rs_exit_inv",   int'(bus.invulnerable), 0);

    // async reset in frame 2 of a window
    tick(1'b1, 1'b0);
    wait_frames(2);
    #2;
    resetN = 1'b0;
    #1;
    check_val("ar_lives", int'(bus.lives), 3);
    check_val("ar_inv",   int'(bus.invulnerable), 0);
    check_val("ar_vis",   int'(bus.player_visible), 1);
    check_val("ar_llp",   int'(bus.life_lost_pulse), 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    tick(1'b1, 1'b0);
    check_val("ar_hit_lives", int'(bus.lives), 2);

    // random phase, at most one hit per frame
    hit_used = 1'b0;
    for (int i = 0; i < 600; i++) begin
      h = 1'b0;
      if (!hit_used && ($urandom_range(0, 5) == 0)) h = 1'b1;
      r = ($urandom_range(0, 79) == 0);
      if (h) hit_used = 1'b1;
      if (sof_next()) hit_used = 1'b0;
      tick(h, r);
    end

    check_val("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
